// File: rtl/clk_freq_meas_pkg.sv
// clk_freq_meas_pkg: FSM state type, default sizing constants and the bit-width helper
package clk_freq_meas_pkg;
  typedef enum logic [1:0] {IDLE, MEAS, DONE} state_e;
  localparam int DEF_GATE_CYCLES = 2500;
  localparam int DEF_CNT_W = 16;
  function automatic int bits_for(input longint unsigned v);
    int r;
    r = 1;
    for (int i = 1; i < 64; i++) if ((v >> i) != 0) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-flop synchronizer followed by a registered rising-edge detector
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic rise
);
  logic s0_q, s1_q, prev_q, rise_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q   <= 1'b0;
      s1_q   <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s0_q   <= d_in;
      s1_q   <= s0_q;
      prev_q <= s1_q;
      rise_q <= s1_q & ~prev_q;
    end
  end
  assign rise = rise_q;
endmodule

// File: rtl/clk_freq_meas.sv
// clk_freq_meas: counts rising edges of sig_in over a GATE_CYCLES window per start request.
// Define CLK_FREQ_MEAS_CONT_EN to add the cont input for back-to-back windows.
module clk_freq_meas
  import clk_freq_meas_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
`ifdef CLK_FREQ_MEAS_CONT_EN
  input  logic             cont,
`endif
  output logic             busy,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_vld,
  output logic             cnt_ovf
);
  localparam int GW = bits_for(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  state_e           state_q;
  logic [GW-1:0]    gate_q;
  logic [CNT_W-1:0] edge_q, edge_d, out_q;
  logic             ovf_q, ovf_d, busy_q, vld_q, ovf_out_q, rise, go_cont;
`ifdef CLK_FREQ_MEAS_CONT_EN
  assign go_cont = cont;
`else
  assign go_cont = 1'b0;
`endif
  sync_edge_det u_sync (.clk(clk), .rst(rst), .d_in(sig_in), .rise(rise));
  // saturating edge count; ovf marks an edge lost while already saturated
  always_comb begin
    edge_d = (rise && !(&edge_q)) ? edge_q + CNT_W'(1) : edge_q;
    ovf_d  = ovf_q | (rise & (&edge_q));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gate_q    <= '0;
      edge_q    <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      vld_q     <= 1'b0;
      out_q     <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= MEAS;
          busy_q  <= 1'b1;
          gate_q  <= '0;
          edge_q  <= '0;
          ovf_q   <= 1'b0;
        end
        MEAS: begin
          gate_q <= gate_q + GW'(1);
          edge_q <= edge_d;
          ovf_q  <= ovf_d;
          if (gate_q == GATE_LAST) begin
            state_q   <= DONE;
            vld_q     <= 1'b1;
            out_q     <= edge_d;
            ovf_out_q <= ovf_d;
          end
        end
        DONE: begin
          state_q <= go_cont ? MEAS : IDLE;
          busy_q  <= go_cont;
          gate_q  <= '0;
          edge_q  <= '0;
          ovf_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy    = busy_q;
  assign cnt_vld = vld_q;
  assign cnt_out = out_q;
  assign cnt_ovf = ovf_out_q;
endmodule

// File: tb/tb_clk_freq_meas.sv
// tb_clk_freq_meas: table-driven frequency windows, control corner cases and a randomized model check.
module tb_clk_freq_meas;
  localparam int G  = 2500;
  localparam int GC = 40;
  localparam int NR = 600;
  typedef struct {int half; int exp_a; int exp_b; bit ovf_b;} vec_t;
  logic clk = 0, rst, start, cont, sig_gen, sig_rnd, gen_mode;
  logic sig_in;
  logic busy_a, vld_a, ovf_a, busy_b, vld_b, ovf_b, busy_c, vld_c, ovf_c;
  logic [15:0] out_a;
  logic [3:0]  out_b, out_c;
  int cyc = 0, total = 0, bad = 0, half = 500;
  vec_t tbl [4];
  logic sig_h [NR];
  assign sig_in = gen_mode ? sig_gen : sig_rnd;
  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    sig_gen = 0;
    #7;
    forever #(half) sig_gen = ~sig_gen;
  end
  initial begin
    #(4000000);
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "timeout");
  end
  clk_freq_meas #(.GATE_CYCLES(G), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start),
`ifdef CLK_FREQ_MEAS_CONT_EN
    .cont(cont),
`endif
    .busy(busy_a), .cnt_out(out_a), .cnt_vld(vld_a), .cnt_ovf(ovf_a));
  clk_freq_meas #(.GATE_CYCLES(G), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start),
`ifdef CLK_FREQ_MEAS_CONT_EN
    .cont(cont),
`endif
    .busy(busy_b), .cnt_out(out_b), .cnt_vld(vld_b), .cnt_ovf(ovf_b));
  clk_freq_meas #(.GATE_CYCLES(GC), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start),
`ifdef CLK_FREQ_MEAS_CONT_EN
    .cont(cont),
`endif
    .busy(busy_c), .cnt_out(out_c), .cnt_vld(vld_c), .cnt_ovf(ovf_c));
  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic chk_near(input string nm, input longint act, input longint exp, input int tol);
    total++;
    if (act < exp - tol || act > exp + tol) begin
      bad++;
      $display("FAIL %s: got %0d want %0d+/-%0d", nm, act, exp, tol);
    end
  endtask
  task automatic pulse_start(output int t0);
    @(negedge clk);
    start = 1;
    t0 = cyc;
    @(negedge clk);
    start = 0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
  endtask
  task automatic collect(input int ncyc, input int t0, output int nv, output int lat,
                         output int last_busy, output int oa, output int ova, output int ob, output int ovb);
    nv = 0; lat = -1; last_busy = -1; oa = 0; ova = 0; ob = 0; ovb = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (busy_a) last_busy = cyc - t0;
      if (vld_a) begin
        if (nv == 0) lat = cyc - t0;
        nv++;
        oa = int'(out_a); ova = int'(ovf_a);
      end
      if (vld_b) begin
        ob = int'(out_b); ovb = int'(ovf_b);
      end
    end
  endtask
  function automatic int h(input int i);
    return (i < 0) ? 0 : int'(sig_h[i]);
  endfunction
  initial begin
    int t0, nv, lat, lb, oa, ova, ob, ovb, ws, sum, eo, eovf;
    bit eb, ev, s;
    tbl[0] = '{500, 100, 15, 1};
    tbl[1] = '{5000, 10, 10, 0};
    tbl[2] = '{1000, 50, 15, 1};
    tbl[3] = '{2000, 25, 15, 1};
    rst = 1; start = 0; cont = 0; gen_mode = 1; sig_rnd = 0;
    repeat (4) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_vld", vld_a, 0);
    chk("rst_out", out_a, 0);
    chk("rst_ovf", ovf_a, 0);
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      half = tbl[k].half;
      repeat (300) @(negedge clk);
      pulse_start(t0);
      collect(G + 20, t0, nv, lat, lb, oa, ova, ob, ovb);
      chk($sformatf("tbl%0d_nvld", k), nv, 1);
      chk($sformatf("tbl%0d_lat", k), lat, G + 1);
      chk_near($sformatf("tbl%0d_cnt16", k), oa, tbl[k].exp_a, 1);
      chk($sformatf("tbl%0d_ovf16", k), ova, 0);
      chk_near($sformatf("tbl%0d_cnt4", k), ob, tbl[k].exp_b, tbl[k].ovf_b ? 0 : 1);
      chk($sformatf("tbl%0d_ovf4", k), ovb, tbl[k].ovf_b);
    end
    half = 500;
    repeat (20) @(negedge clk);
    pulse_start(t0);
    chk("ign_busy_first", busy_a, 1);
    repeat (99) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    collect(G + 40, t0, nv, lat, lb, oa, ova, ob, ovb);
    chk("ign_nvld", nv, 1);
    chk("ign_lat", lat, G + 1);
    chk("ign_busy_last", lb, G + 1);
    chk_near("ign_cnt", oa, 100, 1);
    pulse_start(t0);
    repeat (998) @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    collect(G + 20, t0, nv, lat, lb, oa, ova, ob, ovb);
    chk("abort_nvld", nv, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_out", out_a, 0);
    chk("abort_ovf", ovf_a, 0);
    pulse_start(t0);
    collect(G + 20, t0, nv, lat, lb, oa, ova, ob, ovb);
    chk("after_rst_nvld", nv, 1);
    chk_near("after_rst_cnt", oa, 100, 1);
    chk("after_rst_ovf", ova, 0);
    gen_mode = 0;
    sig_rnd = 0;
    do_reset();
    repeat (6) @(negedge clk);
    ws = -1; eo = 0; eovf = 0;
    for (int r = 0; r < NR; r++) begin
      @(negedge clk);
      eb = (ws >= 0) && (r >= ws + 1) && (r <= ws + GC + 1);
      ev = (ws >= 0) && (r == ws + GC + 1);
      if (ev) begin
        sum = 0;
        for (int m = ws + 1; m <= ws + GC; m++) sum += h(m - 3) & ~h(m - 4) & 1;
        eo = (sum > 15) ? 15 : sum;
        eovf = (sum > 15) ? 1 : 0;
      end
      chk($sformatf("rnd_busy@%0d", r), busy_c, eb);
      chk($sformatf("rnd_vld@%0d", r), vld_c, ev);
      chk($sformatf("rnd_out@%0d", r), out_c, eo);
      if (ev) chk($sformatf("rnd_ovf@%0d", r), ovf_c, eovf);
      sig_rnd = ((r / 100) % 2 == 1) ? ~sig_rnd : 1'($urandom);
      s = ($urandom_range(0, 5) == 0);
      start = s;
      sig_h[r] = sig_rnd;
      if (s && !eb) ws = r;
    end
    start = 0;
`ifdef CLK_FREQ_MEAS_CONT_EN
    gen_mode = 1;
    half = 500;
    do_reset();
    repeat (20) @(negedge clk);
    cont = 1;
    pulse_start(t0);
    nv = 0;
    for (int k = 0; k < 3 * (G + 1) + 40; k++) begin
      @(negedge clk);
      if (cyc - t0 == 2 * (G + 1) + 10) cont = 0;
      if (vld_a) begin
        nv++;
        chk("cont_lat", cyc - t0, nv * (G + 1));
        chk_near("cont_cnt", out_a, 100, 1);
      end
    end
    chk("cont_nvld", nv, 3);
    chk("cont_busy_end", busy_a, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
